// File: rtl/sha_nonce_sched_if.sv
// Bundle for sha_nonce_sched. It carries the job/result signals for the
// job-receive side and the H/W/cycle/hash signals for the sha256 core.
// The master side is the job source (it also returns the core's hash).
// The slave side is the scheduler.
//
// Handshake: start is sampled only while busy is low. A job accepted on an
// edge raises busy from that edge until the edge after its done pulse, or
// until the edge that follows an abort. done is a one-cycle pulse, and found
// and golden_nonce are valid while done is high.
interface sha_nonce_sched_if;
    logic         start;
    logic         abort;
    logic [255:0] midstate;
    logic [95:0]  header_tail;
    logic [255:0] target;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic [255:0] core_hash;
    logic [255:0] core_H;
    logic [511:0] core_W;
    logic [5:0]   core_cycle;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  golden_nonce;
    logic [1:0]   state_dbg;

    modport master (
        output start, abort, midstate, header_tail, target,
               nonce_first, nonce_last, core_hash,
        input  core_H, core_W, core_cycle, busy, done, found,
               golden_nonce, state_dbg
    );

    modport slave (
        input  start, abort, midstate, header_tail, target,
               nonce_first, nonce_last, core_hash,
        output core_H, core_W, core_cycle, busy, done, found,
               golden_nonce, state_dbg
    );
endinterface

// File: rtl/sha_nonce_sched.sv
// Nonce scheduler for a 64-cycle sha256 double-hash core.
// The block latches a job and feeds the core one nonce every 64 cycles. It
// compares each returned digest, read as a little-endian 256-bit integer,
// against the target. It stops on the first hit or when the range runs out.
module sha_nonce_sched (
    input logic              clk,
    input logic              rst,
    sha_nonce_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   next_nonce_q, next_nonce_d;
    logic [31:0]   inflight_nonce_q, inflight_nonce_d;
    logic          inflight_v_q, inflight_v_d;
    logic          last_loaded_q, last_loaded_d;
    logic          found_q, found_d;
    logic [31:0]   golden_q, golden_d;
    logic [255:0]  midstate_q, midstate_d;
    logic [95:0]   tail_q, tail_d;
    logic [255:0]  target_q, target_d;
    logic [31:0]   nonce_last_q, nonce_last_d;

    logic [255:0]  hash_v;
    logic          hash_hit;

    // Reorder the digest so that SHA byte 0 (the top byte of word 0) is the
    // least significant byte of the value compared against the target.
    always_comb begin
        hash_v = '0;
        for (int i = 0; i < 32; i++) begin
            hash_v[8*i +: 8] = bus.core_hash[32*(i/4) + 8*(3 - (i % 4)) +: 8];
        end
        hash_hit = (hash_v <= target_q);
    end

    // Next-state and job bookkeeping. A hit wins over a load on the same
    // cnt==0 edge, and abort wins over both.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        next_nonce_d     = next_nonce_q;
        inflight_nonce_d = inflight_nonce_q;
        inflight_v_d     = inflight_v_q;
        last_loaded_d    = last_loaded_q;
        found_d          = found_q;
        golden_d         = golden_q;
        midstate_d       = midstate_q;
        tail_d           = tail_q;
        target_d         = target_q;
        nonce_last_d     = nonce_last_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = HASH;
                    cnt_d         = 6'd0;
                    next_nonce_d  = bus.nonce_first;
                    inflight_v_d  = 1'b0;
                    last_loaded_d = 1'b0;
                    found_d       = 1'b0;
                    midstate_d    = bus.midstate;
                    tail_d        = bus.header_tail;
                    target_d      = bus.target;
                    nonce_last_d  = bus.nonce_last;
                end
            end
            HASH: begin
                // cnt 63 -> 0 is the natural 6-bit wrap.
                cnt_d = cnt_q + 6'd1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'd0) begin
                    if (inflight_v_q && hash_hit) begin
                        found_d  = 1'b1;
                        golden_d = inflight_nonce_q;
                        state_d  = DONE;
                    end else if (!last_loaded_q) begin
                        inflight_nonce_d = next_nonce_q;
                        inflight_v_d     = 1'b1;
                        last_loaded_d    = (next_nonce_q == nonce_last_q);
                        next_nonce_d     = next_nonce_q + 32'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and job registers; reset drops any running job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            next_nonce_q     <= '0;
            inflight_nonce_q <= '0;
            inflight_v_q     <= 1'b0;
            last_loaded_q    <= 1'b0;
            found_q          <= 1'b0;
            golden_q         <= '0;
            midstate_q       <= '0;
            tail_q           <= '0;
            target_q         <= '0;
            nonce_last_q     <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            next_nonce_q     <= next_nonce_d;
            inflight_nonce_q <= inflight_nonce_d;
            inflight_v_q     <= inflight_v_d;
            last_loaded_q    <= last_loaded_d;
            found_q          <= found_d;
            golden_q         <= golden_d;
            midstate_q       <= midstate_d;
            tail_q           <= tail_d;
            target_q         <= target_d;
            nonce_last_q     <= nonce_last_d;
        end
    end

    // Core drive. The second block is padded for an 80-byte header
    // (0x280 = 640 bits). done is masked by abort, so an abort that lands
    // in DONE never shows a pulse.
    always_comb begin
        bus.core_H       = midstate_q;
        bus.core_W       = {32'h0000_0280, 320'h0, 32'h8000_0000,
                            bswap32(next_nonce_q), tail_q};
        bus.core_cycle   = (state_q == HASH) ? cnt_q : 6'd0;
        bus.busy         = (state_q != IDLE);
        bus.done         = (state_q == DONE) && !bus.abort;
        bus.found        = found_q;
        bus.golden_nonce = golden_q;
        bus.state_dbg    = state_q;
    end
endmodule

// File: tb/tb_sha_nonce_sched.sv
// Bench for sha_nonce_sched. It includes a behavioural double-SHA-256 core
// that captures H/W whenever cycle is 0 and presents the digest one pass
// later.
module tb_sha_nonce_sched;
    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   e0 = 0;
    bit   mon_en = 1'b0;
    logic [31:0]  last_golden = '0;
    logic [255:0] j_mid = '0;
    logic [95:0]  j_tail = '0;
    logic [31:0]  exp_q [$];
    logic [64:0]  res_q [$];

    sha_nonce_sched_if bus ();
    sha_nonce_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        a = hin[31:0];    b = hin[63:32];   c = hin[95:64];   d = hin[127:96];
        e = hin[159:128]; f = hin[191:160]; g = hin[223:192]; h = hin[255:224];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r = {h, g, f, e, d, c, b, a};
        for (int k = 0; k < 8; k++) r[32*k +: 32] = r[32*k +: 32] + hin[32*k +: 32];
        return r;
    endfunction

    function automatic logic [255:0] dhash(input logic [255:0] hmid, input logic [511:0] blk);
        logic [255:0] h1;
        h1 = compress(hmid, blk);
        return compress(SHA_IV, {32'h0000_0100, 192'h0, 32'h8000_0000, h1});
    endfunction

    // behavioural core: capture on cycle 0, result holds for the next pass
    always @(posedge clk) begin
        if (rst) bus.core_hash <= '0;
        else if (bus.busy && bus.core_cycle == 6'd0) bus.core_hash <= dhash(bus.core_H, bus.core_W);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every cycle-0 window of HASH pops one expected nonce word
    always @(negedge clk) begin
        if (mon_en && bus.busy && bus.state_dbg == 2'd1 && bus.core_cycle == 6'd0) begin
            if (exp_q.size() == 0) begin
                check("w_unexpected", 512'(exp_q.size()), 512'd1);
            end else begin
                logic [31:0] w3;
                w3 = exp_q.pop_front();
                check("core_W", bus.core_W, {32'h0000_0280, 320'h0, 32'h8000_0000, w3, j_tail});
                check("core_H", 512'(bus.core_H), 512'(j_mid));
            end
        end
    end

    task automatic wait_cycle(input logic [5:0] v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.core_cycle != v && n < 200);
        check("wait_cycle", 512'(bus.core_cycle), 512'(v));
    endtask

    // driver: one job with k nonces hashed before the end (hit on the k-th,
    // or exhausted after k)
    task automatic run_job(input logic [31:0] first, input logic [31:0] last,
                           input logic [255:0] tgt, input logic [255:0] mid,
                           input logic [95:0] tail, input int k,
                           input bit exp_found, input bit with_abort);
        logic [31:0] exp_golden;
        logic [64:0] r;
        bit seen;
        exp_golden = exp_found ? first + 32'(k - 1) : last_golden;
        j_mid = mid;
        j_tail = tail;
        mon_en = 1'b1;
        for (int i = 0; i <= k; i++) exp_q.push_back(bswap32(first + 32'(i)));
        res_q.push_back({exp_found, exp_golden, 32'(1 + 64 * k)});
        @(negedge clk);
        bus.midstate = mid; bus.header_tail = tail; bus.target = tgt;
        bus.nonce_first = first; bus.nonce_last = last;
        bus.start = 1'b1; bus.abort = with_abort;
        @(negedge clk);
        e0 = cyc;
        bus.start = 1'b0; bus.abort = 1'b0;
        // scramble job inputs: the block must use its latched copy
        bus.midstate = {8{$urandom}}; bus.header_tail = {3{$urandom}};
        bus.target = {8{$urandom}}; bus.nonce_last = $urandom;
        check("busy_rise", 512'(bus.busy), 512'd1);
        check("found_clear", 512'(bus.found), 512'd0);
        seen = 1'b0;
        for (int n = 0; n < 64 * (k + 2) + 8 && !seen; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                r = res_q.pop_front();
                check("found", 512'(bus.found), 512'(r[64]));
                check("golden_nonce", 512'(bus.golden_nonce), 512'(r[63:32]));
                check("done_time", 512'(cyc - e0), 512'(r[31:0]));
            end
        end
        check("done_seen", 512'(seen), 512'd1);
        @(negedge clk);
        check("done_1cyc", 512'(bus.done), 512'd0);
        check("busy_fall", 512'(bus.busy), 512'd0);
        check("w_count", 512'(exp_q.size()), 512'd0);
        exp_q.delete();
        res_q.delete();
        mon_en = 1'b0;
        if (exp_found) last_golden = exp_golden;
    endtask

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0]  chunk1;
        logic [255:0]  gen_mid;
        logic [95:0]   gen_tail;
        logic [31:0]   words [16];
        logic [31:0]   f;
        int            n, dn;

        words = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
                  32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
        for (int i = 0; i < 16; i++) chunk1[32*i +: 32] = words[i];
        gen_mid  = compress(SHA_IV, chunk1);
        gen_tail = {32'hffff001d, 32'h29ab5f49, 32'h4b1e5e4a};

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.midstate = '0; bus.header_tail = '0; bus.target = '0;
        bus.nonce_first = '0; bus.nonce_last = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 512'(bus.busy), 512'd0);
        check("rst_state", 512'(bus.state_dbg), 512'd0);
        rst = 1'b0;

        // single nonce, all-ones target: hit on the only nonce
        run_job(32'h5, 32'h5, {256{1'b1}}, {8{$urandom}}, {3{$urandom}}, 1, 1'b1, 1'b0);

        // reset mid-job
        @(negedge clk);
        bus.nonce_first = 32'h200; bus.nonce_last = 32'h2ff; bus.target = '0;
        bus.midstate = {8{$urandom}}; bus.header_tail = {3{$urandom}};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cycle(6'd20);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 512'(bus.busy), 512'd0);
        check("rst_done", 512'(bus.done), 512'd0);
        check("rst_found", 512'(bus.found), 512'd0);
        check("rst_cycle", 512'(bus.core_cycle), 512'd0);
        check("rst_golden", 512'(bus.golden_nonce), 512'd0);
        check("rst_H", 512'(bus.core_H), 512'd0);
        check("rst_W", bus.core_W, {32'h0000_0280, 320'h0, 32'h8000_0000, 128'h0});
        @(negedge clk);
        rst = 1'b0;
        last_golden = '0;

        // no hit over three nonces
        run_job(32'h10, 32'h12, 256'h0, {8{$urandom}}, {3{$urandom}}, 3, 1'b0, 1'b0);
        // wrap through 0xFFFFFFFF
        run_job(32'hffff_fffe, 32'h1, 256'h0, {8{$urandom}}, {3{$urandom}}, 4, 1'b0, 1'b0);
        // random hit on the first nonce of a short range
        f = $urandom;
        run_job(f, f + 32'($urandom_range(0, 2)), {256{1'b1}}, {8{$urandom}}, {3{$urandom}}, 1, 1'b1, 1'b0);
        // random miss, start accepted together with abort in IDLE
        n = $urandom_range(1, 3);
        f = $urandom;
        run_job(f, f + 32'(n - 1), 256'h0, {8{$urandom}}, {3{$urandom}}, n, 1'b0, 1'b1);
        // genesis block: hit on the 5th nonce
        run_job(32'h7c2bac19, 32'h7c2bac1f, 256'hffff << 208, gen_mid, gen_tail, 5, 1'b1, 1'b0);

        // start while busy is ignored, then abort
        @(negedge clk);
        bus.nonce_first = 32'h100; bus.nonce_last = 32'h1ff; bus.target = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cycle(6'd10);
        bus.start = 1'b1; bus.nonce_first = 32'h5000;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_cycle", 512'(bus.core_cycle), 512'd11);
        check("ign_w3", 512'(bus.core_W[127:96]), 512'(bswap32(32'h101)));
        wait_cycle(6'd30);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 512'(bus.busy), 512'd0);
        check("abort_state", 512'(bus.state_dbg), 512'd0);
        check("abort_found", 512'(bus.found), 512'd0);
        check("abort_golden", 512'(bus.golden_nonce), 512'(last_golden));
        dn = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 512'(dn), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sha_nonce_sched.md
# sha_nonce_sched

Nonce scheduler and result checker for the `sha256` double-hash core. It accepts a mining job (midstate, header tail, target, nonce range) and drives the core's `H`, `W` and `cycle` inputs. Each nonce takes one 64-cycle pass. The block checks every final hash against the target and reports the first winning nonce, or reports that the range is exhausted. It sits between the job-receive logic and a single `sha256` instance.

## Interface
- No parameters.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: accepts a job when idle; ignored while busy.
- `abort` in 1: cancels the running job.
- `midstate` in 256: first-chunk state; word0 at [31:0].
- `header_tail` in 96: header words 16..18 (merkle tail, time, bits), already in SHA word order; word16 at [31:0].
- `target` in 256: unsigned threshold.
- `nonce_first` in 32: first nonce, inclusive.
- `nonce_last` in 32: last nonce, inclusive.
- `core_hash` in 256: `sha256.hash`.
- `core_H` out 256: to `sha256.H`.
- `core_W` out 512: to `sha256.W`.
- `core_cycle` out 6: to `sha256.cycle`.
- `busy` out 1: job in progress.
- `done` out 1: 1-cycle pulse at job end (hit or exhausted).
- `found` out 1: level; set on hit, cleared on next accepted start.
- `golden_nonce` out 32: winning nonce, held until next hit.

## Operation
- States: IDLE, HASH, DONE.
- Job registers: `midstate`, `header_tail`, `target` and `nonce_last` are latched on start and held stable for the whole job.
- `core_H` is the latched midstate.
- `core_W` is built as follows:
  - words 0..2 = latched tail;
  - word3 = byte-swapped `next_nonce`;
  - word4 = 0x80000000;
  - words 5..14 = 0;
  - word15 = 0x00000280.
  - Word k sits at [32k+31:32k].
- `core_cycle` is `cnt` in HASH and 0 in IDLE/DONE.
- Internal registers: `cnt` (6 bits), `next_nonce`, `inflight_nonce`, `inflight_v`, `last_loaded`.
- IDLE, on `start`: go to HASH.
  - Set `cnt` = 0, `next_nonce` = `nonce_first`, `inflight_v` = 0, `last_loaded` = 0, `found` = 0.
- HASH, every edge: `cnt` = `cnt` + 1 (63 wraps to 0).
- HASH, on an edge where `cnt` == 0, evaluate in this order:
  1. Check. If `inflight_v` and V <= `target`, then set `found` = 1 and `golden_nonce` = `inflight_nonce`, and go to DONE. The load below is discarded.
  2. Load. Otherwise, if not `last_loaded`, then set `inflight_nonce` = `next_nonce`, `inflight_v` = 1, `last_loaded` = (`next_nonce` == latched `nonce_last`), and `next_nonce` = `next_nonce` + 1 (mod 2^32).
  3. Exhausted. Otherwise go to DONE with `found` = 0.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Hash value V, used for the check:
  - Digest bytes d0..d31 run in SHA order, with d0 = `core_hash`[31:24] and d31 = `core_hash`[231:224].
  - V = Σ d_i·256^i (little-endian integer), compared unsigned against `target`.
- Nonce range:
  - Wrap-around ranges (`nonce_first` > `nonce_last`) pass through 0xFFFFFFFF to 0.
  - `nonce_first` == `nonce_last` hashes exactly one nonce.
  - `nonce_first` == `nonce_last` + 1 covers all 2^32 nonces.
- `abort` in HASH or DONE:
  - Go to IDLE on the next edge.
  - No `done`; `found` and `golden_nonce` are unchanged.
  - `abort` has priority over the check.
- Simultaneous `start` and `abort` in IDLE: the start is accepted.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `found` 0, `golden_nonce` 0, `core_cycle` 0, and all internal registers 0.
- While `rst` is held: `core_H` = 0, and `core_W` = 0 apart from the constant padding words.
- Reset mid-job drops the job.
- Start is accepted at edge E0.
  - `busy` = 1 from E0+.
  - The first load happens at edge E0+1.
  - The k-th nonce (k = 1..N) is checked at edge E0+1+64k.
- Exhaustion:
  - DONE is entered at E0+1+64N.
  - `done` is high for the cycle after that edge.
  - `busy` falls at E0+2+64N.
- A hit on the k-th nonce gives `done` in the cycle after E0+1+64k.
- Throughput: 64 cycles per nonce.

## Test plan
- Reset: assert `rst` for 2 cycles mid-job (`cnt` ≈ 20) → `busy`/`done`/`found`/`core_cycle`/`golden_nonce` all 0 on the next cycle.
- Single nonce: `nonce_first` = `nonce_last` = 0x00000005, `target` = all-ones → word3 = 0x05000000; `found` = 1, `golden_nonce` = 0x00000005 at E0+65; `done` for one cycle.
- No hit: `target` = 0, range 0x10..0x12 → word3 sequence 0x10000000, 0x11000000, 0x12000000; `done` after E0+193; `found` = 0.
- Genesis block: real midstate/tail, `target` from bits 0x1d00ffff, range 0x7C2BAC19..0x7C2BAC1F → hit on the 5th nonce; `golden_nonce` = 0x7C2BAC1D; `done` after E0+321.
- Wrap: range 0xFFFFFFFE..0x00000001, `target` = 0 → 4 nonces including 0xFFFFFFFF and 0; `done` after E0+257.
- Abort / start while busy: pulse `start` with a new range at `cnt` = 10 → ignored; `abort` at `cnt` = 30 → IDLE next edge; no `done`; `found` unchanged.
